// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues one word request at a time, holds the returned
// instruction with its pc and decoded fields until downstream consumes it.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] jaddr
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } state_t;

    localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic        kill;
    logic [31:0] target;

    assign target   = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;

    // req_addr freezes the in-flight address so a redirect during WAIT only
    // retargets fetch_pc and never disturbs the outstanding request.
    assign imem_req  = !reset && (state != HOLD);
    assign imem_addr = (state == FETCH) ? fetch_pc : req_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC_W;
            req_addr    <= RESET_PC_W;
            pc          <= RESET_PC_W;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            kill        <= 1'b0;
        end else begin
            case (state)
                FETCH, WAIT: begin
                    if (state == FETCH) begin
                        req_addr <= fetch_pc;
                    end
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    // An ack that races a redirect, or returns for a killed
                    // request, is dropped and fetching restarts at fetch_pc.
                    if (imem_ack) begin
                        if (redirect || kill) begin
                            kill  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            instr       <= imem_rdata;
                            pc          <= imem_addr;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else begin
                        if (redirect) begin
                            kill <= 1'b1;
                        end
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fetch_pc    <= redirect ? target : pc_plus4;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign opcode    = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign shamt     = instr[10:6];
    assign funct     = instr[5:0];
    assign immediate = instr[15:0];
    assign jaddr     = instr[25:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: a memory model with random latency, a stimulus
// process that predicts the delivered pc stream, and a monitor scoreboard.
module tb_instr_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] jaddr;

    int          vectors = 0;
    int          miscompares = 0;
    int          consumeCount = 0;
    int          deliveries = 0;
    int          latMin = 1;
    int          latMax = 1;
    int          spuriousPct = 0;
    logic        ackInReset = 1'b0;
    logic [31:0] expQ[$];
    logic [31:0] expNextPc = RESET_PC;

    instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .immediate(immediate), .jaddr(jaddr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h3C01_ABCD;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: one request at a time, random latency, optional stray acks.
    initial begin : memory
        logic        busy;
        int          count;
        logic [31:0] reqAddr;
        busy = 1'b0;
        count = 0;
        reqAddr = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            imem_ack = 1'b0;
            if (reset) begin
                busy = 1'b0;
                if (ackInReset) begin
                    imem_ack = 1'b1;
                    imem_rdata = 32'hBAD0_0BAD;
                end
            end else if (busy) begin
                checkOutput("req_held", {31'd0, imem_req}, 32'd1);
                checkOutput("addr_held", imem_addr, reqAddr);
                count--;
                if (count <= 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = memData(reqAddr);
                    busy = 1'b0;
                end
            end else if (imem_req === 1'b1) begin
                reqAddr = imem_addr;
                checkOutput("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                count = int'($urandom_range(latMax, latMin));
                if (count == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = memData(reqAddr);
                end else begin
                    busy = 1'b1;
                end
            end else if (int'($urandom_range(99, 0)) < spuriousPct) begin
                imem_ack = 1'b1;
                imem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the expected pc whenever a new instruction appears and
    // verifies everything presented while it is held.
    initial begin : monitor
        logic        prevValid;
        logic [31:0] heldPc;
        logic [31:0] heldInstr;
        int          idle;
        prevValid = 1'b0;
        heldPc = 32'd0;
        heldInstr = 32'd0;
        idle = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prevValid = 1'b0;
                idle = 0;
            end else begin
                if (instr_valid && !prevValid) begin
                    deliveries++;
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_instr: got pc %h, expected no delivery", pc);
                    end else begin
                        heldPc = expQ.pop_front();
                        heldInstr = memData(heldPc);
                    end
                end
                if (instr_valid) begin
                    idle = 0;
                    checkOutput("pc", pc, heldPc);
                    checkOutput("instr", instr, heldInstr);
                    checkOutput("pc_plus4", pc_plus4, heldPc + 32'd4);
                    checkOutput("fields", {opcode, rs, rt, rd, shamt, funct}, heldInstr);
                    checkOutput("immediate", {16'd0, immediate}, {16'd0, heldInstr[15:0]});
                    checkOutput("jaddr", {6'd0, jaddr}, {6'd0, heldInstr[25:0]});
                    checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
                end else begin
                    idle++;
                    if (idle > 60) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL fetch_timeout: got %0d idle cycles, expected at most 60", idle);
                        idle = 0;
                    end
                end
                prevValid = instr_valid;
            end
        end
    end

    // Drives one cycle and updates the expected pc stream from the fetch rules.
    task automatic applyStimulus(input logic st, input logic rdir, input logic [31:0] rpc);
        logic [31:0] tgt;
        @(negedge clk);
        stall = st;
        redirect = rdir;
        redirect_pc = rpc;
        tgt = rpc & 32'hFFFF_FFFC;
        if (instr_valid) begin
            if (!st) begin
                expNextPc = rdir ? tgt : expNextPc + 32'd4;
                expQ.push_back(expNextPc);
                consumeCount++;
            end
        end else if (rdir) begin
            if (expQ.size() > 0) void'(expQ.pop_back());
            expNextPc = tgt;
            expQ.push_back(expNextPc);
        end
    endtask

    task automatic doReset(input logic withAck);
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        ackInReset = withAck;
        repeat (2) @(negedge clk);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        expQ.delete();
        expNextPc = RESET_PC;
        expQ.push_back(RESET_PC);
        reset = 1'b0;
        ackInReset = 1'b0;
        #1;
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, RESET_PC);
    endtask

    task automatic consumeN(input int n);
        int goal;
        int guard;
        goal = consumeCount + n;
        guard = 0;
        while (consumeCount < goal && guard < 200) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            guard++;
        end
        checkOutput("consume_bound", {31'd0, guard < 200}, 32'd1);
    endtask

    task automatic randomCycles(input int n);
        logic        st;
        logic        rdir;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            st = int'($urandom_range(99, 0)) < 40;
            rdir = int'($urandom_range(99, 0)) < 12;
            case ($urandom_range(2, 0))
                0: rpc = $urandom_range(255, 0);
                1: rpc = 32'hFFFF_FF00 | $urandom_range(255, 0);
                default: rpc = $urandom;
            endcase
            applyStimulus(st, rdir, rpc);
        end
    endtask

    initial begin : stimulus
        int   guard;
        int   seen;
        logic sawValid;

        // Back-to-back fetches across the address wrap.
        doReset(1'b0);
        consumeN(2);
        latMin = 5;
        latMax = 5;
        consumeN(1);

        // Redirect while waiting on the fetch at 0x8.
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 50) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            if (imem_req && imem_addr == 32'h8 && !instr_valid) seen++;
            guard++;
        end
        checkOutput("wait_at_8", seen, 2);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040);
        sawValid = 1'b0;
        guard = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            if (instr_valid) sawValid = 1'b1;
            guard++;
        end while (!(imem_req && imem_addr != 32'h8) && guard < 50);
        checkOutput("killed_valid", {31'd0, sawValid}, 32'd0);
        checkOutput("killed_next_addr", imem_addr, 32'h0000_0040);

        // Hold 0x3C01ABCD under stall, ignoring a redirect meanwhile.
        latMin = 1;
        latMax = 1;
        guard = 0;
        while (!instr_valid && guard < 50) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i == 2, 32'h0000_0500);
            checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("stall_instr", instr, 32'h3C01_ABCD);
            checkOutput("stall_opcode", {26'd0, opcode}, 32'h0F);
            checkOutput("stall_rs", {27'd0, rs}, 32'd0);
            checkOutput("stall_rt", {27'd0, rt}, 32'd1);
            checkOutput("stall_imm", {16'd0, immediate}, 32'hABCD);
            checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
        end

        // Consume with a misaligned redirect target.
        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("redir_req", {31'd0, imem_req}, 32'd1);
        checkOutput("redir_addr", imem_addr, 32'h0000_0100);

        // Reset in the middle of a wait, with acks arriving during reset.
        latMin = 5;
        latMax = 5;
        applyStimulus(1'b0, 1'b0, 32'd0);
        doReset(1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("post_rst_instr", instr, 32'd0);
        checkOutput("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic with stray acks and a reset in between.
        latMin = 0;
        latMax = 3;
        spuriousPct = 15;
        randomCycles(800);
        doReset(1'($urandom_range(1, 0)));
        randomCycles(800);
        spuriousPct = 0;
        vectors++;
        if (deliveries < 50) begin
            miscompares++;
            $display("[TB] FAIL deliveries: got %0d, expected at least 50", deliveries);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
